// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load opcodes and instruction field positions.
package mem_wb_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;

  // R-type instructions write rd, immediate-form instructions write rt.
  function automatic logic [4:0] destReg(input logic [31:0] instr, input logic useRd);
    return useRd ? instr[RD_HI:RD_LO] : instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bus: instruction and data coming out of MEM, register-file write port going out of WB.
interface mem_wb_stage_if #(
  parameter int COUNT_W = 11
);
  logic               valid_in;
  logic [31:0]        instr_in;
  logic [31:0]        alu_out_in;
  logic [31:0]        mem_rdata_in;
  logic               regdst_in;
  logic               wbdata_in;
  logic               regwrite_in;

  logic               valid;
  logic [31:0]        instr;
  logic               wb_en;
  logic [4:0]         wb_addr;
  logic [31:0]        wb_data;
  logic               align_err;
  logic [COUNT_W-1:0] retired;

  modport master (
    output valid_in, instr_in, alu_out_in, mem_rdata_in, regdst_in, wbdata_in, regwrite_in,
    input  valid, instr, wb_en, wb_addr, wb_data, align_err, retired
  );

  modport slave (
    input  valid_in, instr_in, alu_out_in, mem_rdata_in, regdst_in, wbdata_in, regwrite_in,
    output valid, instr, wb_en, wb_addr, wb_data, align_err, retired
  );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Sub-word load extraction: picks the addressed byte/halfword out of a memory word and extends it.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter bit BIG_END = 1'b1
) (
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [5:0]  opcode_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [1:0]  byteLane;
  logic        halfLane;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lanes are counted from the LSB; big-endian memory puts byte 0 in the top lane.
  assign byteLane = BIG_END ? ~addr_i : addr_i;
  assign halfLane = BIG_END ? ~addr_i[1] : addr_i[1];
  assign byteSel  = word_i[{byteLane, 3'b000} +: 8];
  assign halfSel  = word_i[{halfLane, 4'b0000} +: 16];

  always_comb begin
    data_o       = word_i;
    misaligned_o = 1'b0;
    unique case (opcode_i)
      OP_LW:  misaligned_o = (addr_i != 2'b00);
      OP_LB:  data_o = {{24{byteSel[7]}}, byteSel};
      OP_LBU: data_o = {24'h000000, byteSel};
      OP_LH: begin
        data_o       = {{16{halfSel[15]}}, halfSel};
        misaligned_o = addr_i[0];
      end
      OP_LHU: begin
        data_o       = {16'h0000, halfSel};
        misaligned_o = addr_i[0];
      end
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects write-back data and destination, and presents a registered
// register-file write port that also serves as the WB forwarding source.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int COUNT_W = 11,
  parameter bit BIG_END = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  mem_wb_stage_if.slave bus
);

  logic [31:0]        loadData;
  logic               loadMisaligned;
  logic               misaligned;
  logic [4:0]         wbAddr_d;
  logic [31:0]        wbData_d;
  logic               wbEn_d;
  logic               alignErr_d;

  logic               valid_q;
  logic [31:0]        instr_q;
  logic               wbEn_q;
  logic [4:0]         wbAddr_q;
  logic [31:0]        wbData_q;
  logic               alignErr_q;
  logic [COUNT_W-1:0] retired_q;

  load_align #(.BIG_END(BIG_END)) uLoadAlign (
    .word_i      (bus.mem_rdata_in),
    .addr_i      (bus.alu_out_in[1:0]),
    .opcode_i    (bus.instr_in[OPC_HI:OPC_LO]),
    .data_o      (loadData),
    .misaligned_o(loadMisaligned)
  );

  // A misaligned access only matters when the instruction actually writes back load data.
  always_comb begin
    wbAddr_d   = destReg(bus.instr_in, bus.regdst_in);
    misaligned = bus.wbdata_in & loadMisaligned;
    wbData_d   = bus.wbdata_in ? loadData : bus.alu_out_in;
    wbEn_d     = bus.valid_in & bus.regwrite_in & (wbAddr_d != 5'd0) & ~misaligned;
    alignErr_d = bus.valid_in & misaligned;
  end

  // Flush beats stall; the retired counter survives flushes and only counts real instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      wbEn_q     <= 1'b0;
      wbAddr_q   <= '0;
      wbData_q   <= '0;
      alignErr_q <= 1'b0;
      retired_q  <= '0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      wbEn_q     <= 1'b0;
      wbAddr_q   <= '0;
      wbData_q   <= '0;
      alignErr_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= bus.valid_in;
      instr_q    <= bus.instr_in;
      wbEn_q     <= wbEn_d;
      wbAddr_q   <= wbAddr_d;
      wbData_q   <= wbData_d;
      alignErr_q <= alignErr_d;
      if (bus.valid_in) begin
        retired_q <= retired_q + COUNT_W'(1);
      end
    end
  end

  assign bus.valid     = valid_q;
  assign bus.instr     = instr_q;
  assign bus.wb_en     = wbEn_q;
  assign bus.wb_addr   = wbAddr_q;
  assign bus.wb_data   = wbData_q;
  assign bus.align_err = alignErr_q;
  assign bus.retired   = retired_q;

endmodule
